// File: rtl/eth_pkg.sv
// Shared Ethernet constants, framer state encoding and the byte-wide CRC-32 step.
// The receive path reuses these constants.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_PAY,
        ST_PAD,
        ST_FCS,
        ST_UNDR,
        ST_IFG
    } tx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam int          MIN_BODY_BYTES = 60;
    localparam logic [31:0] CRC_POLY       = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;

    // Reflected (LSB-first) CRC-32 update for one byte.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] poly_r;
        logic [31:0] c;
        for (int i = 0; i < 32; i++) poly_r[i] = CRC_POLY[31-i];
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ poly_r) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 accumulator with synchronous clear and enable.
// Shared by the transmit framer and the receive FCS check.
module eth_crc32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    import eth_pkg::*;

    always_ff @(posedge clock) begin
        if (reset) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= crc32_next(crc, data);
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// GMII transmit framer: preamble, header words from data memory, payload queue words,
// zero pad to minimum body length, then FCS and inter-frame gap.
//
// state | meaning
// IDLE  | waiting for start
// PRE   | 7 x 55 + D5
// HDR   | header bytes from data memory
// PAY   | payload bytes from queue
// PAD   | zero fill up to minimum body
// FCS   | ~crc, LSB first
// UNDR  | single txer byte after queue underrun
// IFG   | idle gap, done on last cycle
module eth_tx_framer #(
    parameter int HDR_WORDS   = 4,
    parameter int PAYLOAD_MAX = 371,
    parameter int IFG_BYTES   = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  hdrBase,
    input  logic [8:0]  payloadWords,
    output logic        busy,
    output logic        done,
    output logic [9:0]  DMaddr,
    input  logic [31:0] DMdata,
    input  logic [31:0] plData,
    input  logic        plValid,
    output logic        plRead,
    output logic [7:0]  txd,
    output logic        txen,
    output logic        txer
);
    import eth_pkg::*;

    localparam logic [8:0]  HDR_LAST  = 9'(HDR_WORDS - 1);
    localparam logic [8:0]  PAY_MAX   = 9'(PAYLOAD_MAX);
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_BYTES - 1);
    localparam logic [10:0] BODY_LAST = 11'(MIN_BODY_BYTES - 1);

    tx_state_t   state;
    logic [7:0]  cnt;
    logic [1:0]  bcnt;
    logic [8:0]  word_cnt;
    logic [8:0]  pay_len;
    logic [10:0] body_cnt;
    logic [23:0] hdr_word;
    logic [31:0] pay_word;
    logic [31:0] crc_val;
    logic [31:0] fcs;
    logic [7:0]  body_byte;
    logic [7:0]  fcs_byte;
    logic        crc_clr;
    logic        crc_en;

    // First header byte comes straight from the memory port; the rest from the held word.
    always_comb begin
        body_byte = 8'h00;
        case (state)
            ST_HDR: begin
                case (bcnt)
                    2'd0:    body_byte = DMdata[31:24];
                    2'd1:    body_byte = hdr_word[23:16];
                    2'd2:    body_byte = hdr_word[15:8];
                    default: body_byte = hdr_word[7:0];
                endcase
            end
            ST_PAY: begin
                case (bcnt)
                    2'd0:    body_byte = pay_word[31:24];
                    2'd1:    body_byte = pay_word[23:16];
                    2'd2:    body_byte = pay_word[15:8];
                    default: body_byte = pay_word[7:0];
                endcase
            end
            default: body_byte = 8'h00;
        endcase
    end

    assign fcs = ~crc_val;

    always_comb begin
        case (cnt[1:0])
            2'd0:    fcs_byte = fcs[7:0];
            2'd1:    fcs_byte = fcs[15:8];
            2'd2:    fcs_byte = fcs[23:16];
            default: fcs_byte = fcs[31:24];
        endcase
    end

    assign crc_clr = (state == ST_IDLE) && start;
    assign crc_en  = (state == ST_HDR) || (state == ST_PAY) || (state == ST_PAD);

    eth_crc32 u_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clr),
        .enable (crc_en),
        .data   (body_byte),
        .crc    (crc_val)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            plRead   <= 1'b0;
            txen     <= 1'b0;
            txer     <= 1'b0;
            txd      <= 8'h00;
            DMaddr   <= 10'h000;
            cnt      <= 8'h00;
            bcnt     <= 2'd0;
            word_cnt <= 9'd0;
            pay_len  <= 9'd0;
            body_cnt <= 11'd0;
            hdr_word <= 24'h0;
            pay_word <= 32'h0;
        end else begin
            done   <= 1'b0;
            plRead <= 1'b0;
            case (state)
                ST_IDLE: begin
                    txen <= 1'b0;
                    txer <= 1'b0;
                    txd  <= 8'h00;
                    if (start) begin
                        pay_len  <= (payloadWords > PAY_MAX) ? PAY_MAX : payloadWords;
                        DMaddr   <= hdrBase;
                        busy     <= 1'b1;
                        cnt      <= 8'h00;
                        bcnt     <= 2'd0;
                        word_cnt <= 9'd0;
                        body_cnt <= 11'd0;
                        state    <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    txen <= 1'b1;
                    txd  <= (cnt == 8'd7) ? SFD_BYTE : PREAMBLE_BYTE;
                    cnt  <= cnt + 8'd1;
                    if (cnt == 8'd7) begin
                        cnt   <= 8'h00;
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    txen     <= 1'b1;
                    txd      <= body_byte;
                    body_cnt <= body_cnt + 11'd1;
                    bcnt     <= bcnt + 2'd1;
                    if (bcnt == 2'd0) hdr_word <= DMdata[23:0];
                    // Advance early enough for the one-cycle memory latency to settle.
                    if (bcnt == 2'd2) DMaddr <= DMaddr + 10'd1;
                    if (bcnt == 2'd3) begin
                        if (word_cnt == HDR_LAST) begin
                            word_cnt <= 9'd0;
                            if (pay_len == 9'd0) begin
                                state <= (body_cnt < BODY_LAST) ? ST_PAD : ST_FCS;
                            end else if (plValid) begin
                                pay_word <= plData;
                                plRead   <= 1'b1;
                                state    <= ST_PAY;
                            end else begin
                                state <= ST_UNDR;
                            end
                        end else begin
                            word_cnt <= word_cnt + 9'd1;
                        end
                    end
                end
                ST_PAY: begin
                    txen     <= 1'b1;
                    txd      <= body_byte;
                    body_cnt <= body_cnt + 11'd1;
                    bcnt     <= bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        if (word_cnt == pay_len - 9'd1) begin
                            state <= (body_cnt < BODY_LAST) ? ST_PAD : ST_FCS;
                        end else if (plValid) begin
                            pay_word <= plData;
                            plRead   <= 1'b1;
                            word_cnt <= word_cnt + 9'd1;
                        end else begin
                            state <= ST_UNDR;
                        end
                    end
                end
                ST_PAD: begin
                    txen     <= 1'b1;
                    txd      <= 8'h00;
                    body_cnt <= body_cnt + 11'd1;
                    if (body_cnt == BODY_LAST) state <= ST_FCS;
                end
                ST_FCS: begin
                    txen <= 1'b1;
                    txd  <= fcs_byte;
                    cnt  <= cnt + 8'd1;
                    if (cnt == 8'd3) begin
                        cnt   <= 8'h00;
                        state <= ST_IFG;
                    end
                end
                ST_UNDR: begin
                    txen  <= 1'b1;
                    txer  <= 1'b1;
                    txd   <= 8'h00;
                    cnt   <= 8'h00;
                    state <= ST_IFG;
                end
                ST_IFG: begin
                    txen <= 1'b0;
                    txer <= 1'b0;
                    txd  <= 8'h00;
                    if (cnt == IFG_LAST) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= 8'h00;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: expected GMII bytes are queued per frame and
// popped on every txen cycle; also exercises eth_crc32 on its own.
module tb_eth_tx_framer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [9:0]  hdrBase;
    logic [8:0]  payloadWords;
    logic        busy;
    logic        done;
    logic [9:0]  DMaddr;
    logic [31:0] DMdata;
    logic [31:0] plData;
    logic        plValid;
    logic        plRead;
    logic [7:0]  txd;
    logic        txen;
    logic        txer;

    logic        c_clr;
    logic        c_en;
    logic [7:0]  c_data;
    logic [31:0] c_out;

    logic [31:0] dm [1024];
    logic [31:0] pl_q [$];
    logic [9:0]  exp_q [$];
    logic [9:0]  dm_seen [$];
    bit          pl_en;
    int          pops;
    int          n_tests;
    int          n_fail;

    eth_tx_framer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .hdrBase      (hdrBase),
        .payloadWords (payloadWords),
        .busy         (busy),
        .done         (done),
        .DMaddr       (DMaddr),
        .DMdata       (DMdata),
        .plData       (plData),
        .plValid      (plValid),
        .plRead       (plRead),
        .txd          (txd),
        .txen         (txen),
        .txer         (txer)
    );

    eth_crc32 u_crc_alone (
        .clock  (clock),
        .reset  (reset),
        .clear  (c_clr),
        .enable (c_en),
        .data   (c_data),
        .crc    (c_out)
    );

    initial clock = 1'b0;
    always #4 clock = ~clock;

    always @(posedge clock) DMdata <= dm[DMaddr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    always @(posedge clock) begin
        if (plRead) begin
            chk("plread_when_valid", {31'b0, plValid}, 32'd1);
            pops++;
            if (pl_q.size() > 0) void'(pl_q.pop_front());
        end
    end

    always @(negedge clock) begin
        plValid = pl_en && (pl_q.size() != 0);
        plData  = (pl_q.size() != 0) ? pl_q[0] : 32'h0;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic run_frame(input logic [9:0] base, input int nwords, input int nvalid,
                             input bit poke, input int exp_txen);
        int          eff;
        int          txen_cnt;
        int          idle;
        bit          seen;
        bit          stray;
        logic [7:0]  body [$];
        logic [31:0] w;
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [9:0]  a;
        logic [9:0]  e;
        eff = (nwords > 371) ? 371 : nwords;
        exp_q.delete();
        dm_seen.delete();
        pops = 0;
        for (int i = 0; i < 7; i++) exp_q.push_back({2'b00, 8'h55});
        exp_q.push_back({2'b00, 8'hD5});
        for (int k = 0; k < 4; k++) begin
            a = base + 10'(k);
            w = dm[a];
            body.push_back(w[31:24]); body.push_back(w[23:16]);
            body.push_back(w[15:8]);  body.push_back(w[7:0]);
        end
        for (int i = 0; i < nvalid; i++) begin
            w = $urandom;
            pl_q.push_back(w);
            body.push_back(w[31:24]); body.push_back(w[23:16]);
            body.push_back(w[15:8]);  body.push_back(w[7:0]);
        end
        if (nvalid < eff) begin
            foreach (body[i]) exp_q.push_back({2'b00, body[i]});
            exp_q.push_back({2'b11, 8'h00});
        end else begin
            while (body.size() < 60) body.push_back(8'h00);
            crc = 32'hFFFFFFFF;
            foreach (body[i]) begin
                crc = crc_upd(crc, body[i]);
                exp_q.push_back({2'b00, body[i]});
            end
            fcs = ~crc;
            exp_q.push_back({2'b00, fcs[7:0]});
            exp_q.push_back({2'b00, fcs[15:8]});
            exp_q.push_back({2'b00, fcs[23:16]});
            exp_q.push_back({2'b00, fcs[31:24]});
        end
        pl_en = 1'b1;
        @(negedge clock);
        @(negedge clock);
        start        = 1'b1;
        hdrBase      = base;
        payloadWords = 9'(nwords);
        @(negedge clock);
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        txen_cnt = 0;
        idle     = 0;
        seen     = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            if (busy && (dm_seen.size() == 0 || dm_seen[$] != DMaddr)) dm_seen.push_back(DMaddr);
            if (poke) begin
                if (cyc == 20) begin
                    start        = 1'b1;
                    hdrBase      = 10'h155;
                    payloadWords = 9'd2;
                end else if (cyc == 21) begin
                    start = 1'b0;
                end
            end
            if (txen) begin
                txen_cnt++;
                idle = 0;
                if (exp_q.size() == 0) begin
                    chk("txen_unexpected", {31'b0, txen}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (!e[9]) chk("txd", {24'b0, txd}, {24'b0, e[7:0]});
                    chk("txer", {31'b0, txer}, {31'b0, e[8]});
                end
            end else begin
                idle++;
            end
            if (done) begin
                seen = 1'b1;
                chk("idle_before_done", idle, 12);
                chk("busy_with_done", {31'b0, busy}, 32'd0);
            end else begin
                @(negedge clock);
            end
        end
        chk("done_seen", {31'b0, seen}, 32'd1);
        chk("txen_cycles", txen_cnt, exp_txen);
        chk("exp_left", exp_q.size(), 0);
        chk("pops", pops, (nvalid < eff) ? nvalid : eff);
        stray = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (txen || busy || done) stray = 1'b1;
        end
        chk("quiet_after_done", {31'b0, stray}, 32'd0);
    endtask

    task automatic run_reset_test();
        int n;
        bit hit;
        bit stray;
        exp_q.delete();
        @(negedge clock);
        start        = 1'b1;
        hdrBase      = 10'h010;
        payloadWords = 9'd0;
        @(negedge clock);
        start = 1'b0;
        n   = 0;
        hit = 1'b0;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            if (txen) n++;
            if (n == 12) hit = 1'b1;
            else @(negedge clock);
        end
        chk("reset_reached_hdr", {31'b0, hit}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("reset_txen", {31'b0, txen}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        stray = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done || txen || plRead) stray = 1'b1;
        end
        chk("no_done_after_reset", {31'b0, stray}, 32'd0);
    endtask

    logic [9:0] wrap_exp [4];

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        pops         = 0;
        reset        = 1'b1;
        start        = 1'b0;
        hdrBase      = 10'h000;
        payloadWords = 9'd0;
        pl_en        = 1'b0;
        c_clr        = 1'b0;
        c_en         = 1'b0;
        c_data       = 8'h00;
        for (int i = 0; i < 1024; i++) dm[i] = $urandom;
        dm[16] = 32'h00112233;
        dm[17] = 32'h44556677;
        dm[18] = 32'h8899AABB;
        dm[19] = 32'hCCDDEEFF;
        wrap_exp[0] = 10'h3FE;
        wrap_exp[1] = 10'h3FF;
        wrap_exp[2] = 10'h000;
        wrap_exp[3] = 10'h001;

        repeat (3) @(negedge clock);
        chk("rst_busy",   {31'b0, busy},   32'd0);
        chk("rst_done",   {31'b0, done},   32'd0);
        chk("rst_txen",   {31'b0, txen},   32'd0);
        chk("rst_txer",   {31'b0, txer},   32'd0);
        chk("rst_plread", {31'b0, plRead}, 32'd0);
        chk("rst_txd",    {24'b0, txd},    32'd0);
        chk("rst_dmaddr", {22'b0, DMaddr}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        c_clr = 1'b1;
        @(negedge clock);
        c_clr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            c_en   = 1'b1;
            c_data = 8'(8'h31 + i);
            @(negedge clock);
        end
        c_en = 1'b0;
        chk("crc_123456789", ~c_out, 32'hCBF43926);

        run_frame(10'h010, 0, 0, 1'b0, 72);
        run_frame(10'h020, 11, 11, 1'b1, 72);
        run_frame(10'h040, 100, 100, 1'b0, 428);
        run_frame(10'h080, 400, 371, 1'b0, 1512);
        run_frame(10'h100, 6, 3, 1'b0, 37);
        run_frame(10'h3FE, 0, 0, 1'b0, 72);
        for (int i = 0; i < 4; i++) begin
            chk("dmaddr_wrap", (i < dm_seen.size()) ? {22'b0, dm_seen[i]} : 32'hFFFF_FFFF,
                {22'b0, wrap_exp[i]});
        end
        run_reset_test();
        run_frame(10'h010, 11, 11, 1'b0, 72);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
